// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. One full-adder cell is reused across
// WIDTH cycles, LSB first, with a carry flip-flop linking successive bits.
// The result, carry-out and signed overflow are registered and held until the
// next completion.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  // Bit counter only has to reach WIDTH-1.
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CntW-1:0]  cnt;

  logic             cell_sum;
  logic             cell_carry;
  logic [WIDTH-1:0] res_next;

  // The shared full-adder cell and the result register after this cycle's shift.
  always_comb begin
    cell_sum   = op_a[0] ^ op_b[0] ^ carry;
    cell_carry = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    res_next   = {cell_sum, res_sr[WIDTH-1:1]};
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      op_a   <= '0;
      op_b   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            carry  <= sub;
            cnt    <= '0;
            res_sr <= '0;
            busy   <= 1'b1;
            state  <= StRun;
          end
        end
        StRun: begin
          res_sr <= res_next;
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          carry  <= cell_carry;
          cnt    <= cnt + CntW'(1);
          if (cnt == LastCnt) begin
            sum   <= res_next;
            c_out <= cell_carry;
            // carry still holds the carry into the MSB at this point.
            ovf   <= carry ^ cell_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int checks;
  int failures;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launch one operation (start sampled at edge 0) and watch 20 cycles.
  // With disturb set, inputs change and start pulses again at edge 3.
  task automatic run_op(input string tag, input logic s, input logic [7:0] va,
                        input logic [7:0] vb, input logic [7:0] exp_sum,
                        input logic exp_c, input logic exp_ovf, input bit disturb);
    int n_busy;
    int n_done;
    int done_at;
    n_busy  = 0;
    n_done  = 0;
    done_at = -1;
    @(negedge clk);
    sub   = s;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = i;
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      end
      if (disturb && i == 2) begin
        a     = 8'hFF;
        b     = 8'hFF;
        sub   = 1'b1;
        start = 1'b1;
      end
      if (disturb && i == 3) start = 1'b0;
    end
    check_eq({tag, "_busy_cycles"}, 32'(n_busy), 32'd8);
    check_eq({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    check_eq({tag, "_done_edge"}, 32'(done_at), 32'd8);
    check_eq({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check_eq({tag, "_c_out"}, 32'(c_out), 32'(exp_c));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    int n_busy;
    int n_done;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_c_out", 32'(c_out), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("add_35_4a", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b0);
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("disturb", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b1);

    // Result from the previous op must hold while a new op is in RUN.
    @(negedge clk);
    sub   = 1'b0;
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("hold_busy", 32'(busy), 32'd1);
    check_eq("hold_sum", 32'(sum), 32'h7F);
    repeat (10) @(negedge clk);
    check_eq("hold_new_sum", 32'(sum), 32'h02);

    // Reset at edge 4 of a run aborts it with no done pulse afterwards.
    @(negedge clk);
    sub   = 1'b0;
    a     = 8'h35;
    b     = 8'h4A;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_busy = 0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (done) n_done++;
    end
    check_eq("abort_no_done", 32'(n_done), 32'd0);
    check_eq("abort_idle", 32'(n_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
